// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge: FSM states, request length
// encodings, error fill word and beat address generation.
package cpu_bus_pkg;

    typedef enum logic [1:0] {StIdle, StRdBeat, StWrBeat, StGap} state_e;

    localparam logic [2:0]  LenOne        = 3'd1;
    localparam logic [2:0]  LenFour       = 3'd4;
    localparam logic [31:0] ErrFill       = 32'hFFFF_FFFF;
    localparam int unsigned TmoCycDefault = 255;

    // Word address of beat n; wrapped bursts stay inside the 16-byte line.
    function automatic logic [29:0] beat_addr(input logic [31:0] addr, input logic [1:0] n,
                                              input logic burst, input logic wrap);
        logic [29:0] a;
        if (!burst) begin
            a = addr[31:2];
        end else if (wrap) begin
            a = {addr[31:4], addr[3:2] + n};
        end else begin
            a = addr[31:2] + {28'd0, n};
        end
        return a;
    endfunction

endpackage

// File: rtl/bridge_fifo.sv
// First-word fall-through FIFO with full/empty flags. A push while full is dropped unless a
// pop happens in the same cycle, in which case occupancy stays constant.
module bridge_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = Depth[AW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cpu_wb_bridge.sv
// CPU request port to Wishbone classic master with read/write data buffers and sticky error.
// Define CPU_WB_BRIDGE_TIMEOUT_EN to abort beats that see no ack/err within TMO_CYC cycles.
module cpu_wb_bridge
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RD_DEPTH = 4,
    parameter int unsigned WR_DEPTH = 4,
    parameter int unsigned TMO_CYC  = TmoCycDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_len,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic        req_wrap,
    input  logic        write_valid,
    input  logic [31:0] write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    input  logic        read_ack,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [2:0]  len_q;
    logic [3:0]  mask_q;
    logic [31:0] addr_q;
    logic        we_q, wrap_q, err_q;
    logic [1:0]  beat_q;

    logic        rd_push, rd_full, rd_empty;
    logic [31:0] rd_push_data;
    logic        wr_pop, wr_full, wr_empty, wr_overflow;
    logic [31:0] wr_head;
    logic        accept, last_beat, beat_done, beat_err, tmo_hit;

    assign req_ready = (state_q == StIdle) & rd_empty & wr_empty;
    assign accept    = req_valid & req_ready;
    assign last_beat = ({1'b0, beat_q} == len_q - 3'd1);
    assign beat_done = wb_stb_o & (wb_ack_i | wb_err_i | tmo_hit);
    assign beat_err  = wb_err_i | tmo_hit;

`ifdef CPU_WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
    logic [TmoW-1:0] tmo_cnt_q;

    // Counts stalled strobe cycles; the abort fires on the TMO_CYC-th one.
    assign tmo_hit = wb_stb_o & (tmo_cnt_q == TmoW'(TMO_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (!wb_stb_o || beat_done) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end
`else
    // Beats wait forever; TMO_CYC is still referenced so both builds share one interface.
    assign tmo_hit = 1'b0 & (TMO_CYC != 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:             if (accept) state_d = req_we ? StWrBeat : StRdBeat;
            StRdBeat, StWrBeat: if (beat_done) state_d = last_beat ? StIdle : StGap;
            StGap:              state_d = we_q ? StWrBeat : StRdBeat;
            default:            state_d = StIdle;
        endcase
    end

    always_comb begin
        wb_stb_o = 1'b0;
        wb_cyc_o = 1'b0;
        unique case (state_q)
            StRdBeat: begin
                wb_stb_o = 1'b1;
                wb_cyc_o = 1'b1;
            end
            StWrBeat: begin
                wb_stb_o = ~wr_empty;
                wb_cyc_o = ~wr_empty | (beat_q != 2'd0);
            end
            StGap:    wb_cyc_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q  <= LenOne;
            mask_q <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            wrap_q <= 1'b0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                len_q  <= (req_len == LenFour) ? LenFour : LenOne;
                mask_q <= req_mask;
                addr_q <= req_addr;
                we_q   <= req_we;
                wrap_q <= req_wrap;
                beat_q <= '0;
            end else if (beat_done) begin
                beat_q <= beat_q + 2'd1;
            end
            if ((rd_push & rd_full) | wr_overflow | (beat_done & beat_err)) err_q <= 1'b1;
        end
    end

    assign rd_push      = (state_q == StRdBeat) & beat_done;
    assign rd_push_data = beat_err ? ErrFill : wb_dat_i;
    assign wr_pop       = (state_q == StWrBeat) & beat_done;
    assign wr_overflow  = write_valid & wr_full & ~wr_pop;

    assign wb_we_o    = we_q;
    assign wb_sel_o   = mask_q;
    assign wb_adr_o   = beat_addr(addr_q, beat_q, len_q == LenFour, wrap_q);
    assign wb_dat_o   = wr_empty ? '0 : wr_head;
    assign err_o      = err_q;
    assign read_valid = ~rd_empty;

    bridge_fifo #(
        .Width(32),
        .Depth(RD_DEPTH)
    ) u_rd_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (rd_push),
        .push_data(rd_push_data),
        .pop      (read_ack),
        .head     (read_data),
        .full     (rd_full),
        .empty    (rd_empty)
    );

    bridge_fifo #(
        .Width(32),
        .Depth(WR_DEPTH)
    ) u_wr_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (write_valid),
        .push_data(write_data),
        .pop      (wr_pop),
        .head     (wr_head),
        .full     (wr_full),
        .empty    (wr_empty)
    );

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Directed bench for cpu_wb_bridge: reset, single/wrapped/error reads, burst and late writes,
// write-buffer overflow and reset in the middle of a burst.
module tb_cpu_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid, req_ready, req_we, req_wrap;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic        write_valid;
    logic [31:0] write_data;
    logic        read_valid, read_ack;
    logic [31:0] read_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i, err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    cpu_wb_bridge dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_len    (req_len),
        .req_mask   (req_mask),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wrap   (req_wrap),
        .write_valid(write_valid),
        .write_data (write_data),
        .read_valid (read_valid),
        .read_data  (read_data),
        .read_ack   (read_ack),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .err_o      (err_o)
    );

    task automatic drive_req(input logic we, input logic [2:0] len, input logic [31:0] addr,
                             input logic [3:0] mask, input logic wrap);
        @(negedge clk_i);
        req_valid = 1'b1;
        req_we    = we;
        req_len   = len;
        req_addr  = addr;
        req_mask  = mask;
        req_wrap  = wrap;
        @(posedge clk_i);
        #1 req_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] d);
        @(negedge clk_i);
        write_valid = 1'b1;
        write_data  = d;
        @(posedge clk_i);
        #1 write_valid = 1'b0;
    endtask

    task automatic pop_rd();
        read_ack = 1'b1;
        @(posedge clk_i);
        #1 read_ack = 1'b0;
    endtask

    task automatic ack_beat(input logic [31:0] d, input logic err);
        wb_dat_i = d;
        wb_ack_i = ~err;
        wb_err_i = err;
        @(posedge clk_i);
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (wb_stb_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid = 0; req_we = 0; req_len = 0; req_addr = 0; req_mask = 0; req_wrap = 0;
        write_valid = 0; write_data = 0; read_ack = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
        #3;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, err_o, read_valid} !== '0)
        begin
            failures++;
            $display("FAIL reset_outputs got cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h err=%b rv=%b exp all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, err_o, read_valid);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_single_read();
        bit ok;
        drive_req(1'b0, 3'd1, 32'h0000_1006, 4'b0011, 1'b0);
        wait_stb(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_stb got=timeout exp=stb"); end
        checks++;
        if (wb_adr_o !== 30'h401 || wb_sel_o !== 4'b0011 || wb_we_o !== 1'b0 || wb_cyc_o !== 1'b1)
        begin
            failures++;
            $display("FAIL single_beat got adr=%h sel=%b we=%b cyc=%b exp adr=401 sel=0011 we=0 cyc=1",
                     wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (wb_stb_o !== 1'b1) begin
                failures++;
                $display("FAIL single_stb_hold got=%b exp=1", wb_stb_o);
            end
        end
        ack_beat(32'hDEAD_BEEF, 1'b0);
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b0 || read_valid !== 1'b1 || read_data !== 32'hDEAD_BEEF ||
            req_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_data got cyc=%b rv=%b rd=%h rdy=%b exp cyc=0 rv=1 rd=deadbeef rdy=0",
                     wb_cyc_o, read_valid, read_data, req_ready);
        end
        pop_rd();
        @(negedge clk_i);
        checks++;
        if (read_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_drain got rv=%b rdy=%b exp rv=0 rdy=1", read_valid, req_ready);
        end
    endtask

    task automatic test_wrap_read();
        bit ok;
        logic [29:0] exp_adr [4];
        exp_adr = '{30'h42, 30'h43, 30'h40, 30'h41};
        drive_req(1'b0, 3'd4, 32'h0000_0108, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_stb(ok);
            checks++;
            if (!ok || wb_adr_o !== exp_adr[i]) begin
                failures++;
                $display("FAIL wrap_adr beat=%0d got=%h ok=%b exp=%h", i, wb_adr_o, ok, exp_adr[i]);
            end
            ack_beat(32'hA000_0000 + 32'(i), 1'b0);
            @(negedge clk_i);
            checks++;
            if (i < 3 && (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0)) begin
                failures++;
                $display("FAIL wrap_gap beat=%0d got cyc=%b stb=%b exp cyc=1 stb=0", i, wb_cyc_o,
                         wb_stb_o);
            end else if (i == 3 && wb_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL wrap_cyc_end got=%b exp=0", wb_cyc_o);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (read_valid !== 1'b1 || read_data !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL wrap_rdata idx=%0d got rv=%b rd=%h exp rv=1 rd=%h", i, read_valid,
                         read_data, 32'hA000_0000 + 32'(i));
            end
            pop_rd();
        end
        @(negedge clk_i);
        checks++;
        if (read_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_drain got rv=%b rdy=%b exp rv=0 rdy=1", read_valid, req_ready);
        end
    endtask

    task automatic test_write_burst();
        bit ok;
        logic [31:0] wd [4];
        wd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        drive_req(1'b1, 3'd4, 32'h0000_0200, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) push_wr(wd[i]);
        for (int i = 0; i < 4; i++) begin
            wait_stb(ok);
            checks++;
            if (!ok || wb_adr_o !== 30'h80 + 30'(i) || wb_dat_o !== wd[i] || wb_we_o !== 1'b1 ||
                wb_sel_o !== 4'hF) begin
                failures++;
                $display("FAIL wr_beat beat=%0d got adr=%h dat=%h we=%b sel=%h ok=%b exp adr=%h dat=%h we=1 sel=f",
                         i, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, ok, 30'h80 + 30'(i), wd[i]);
            end
            ack_beat(32'h0, 1'b0);
            @(negedge clk_i);
            checks++;
            if (wb_cyc_o !== (i < 3)) begin
                failures++;
                $display("FAIL wr_cyc beat=%0d got=%b exp=%b", i, wb_cyc_o, i < 3);
            end
        end
        checks++;
        if (err_o !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_end got err=%b rdy=%b exp err=0 rdy=1", err_o, req_ready);
        end
    endtask

    task automatic test_write_late();
        bit ok;
        drive_req(1'b1, 3'd1, 32'h0000_0010, 4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL late_idle cyc=%0d got stb=%b cyc=%b exp 0 0", i, wb_stb_o, wb_cyc_o);
            end
        end
        push_wr(32'hCAFE_F00D);
        wait_stb(ok);
        checks++;
        if (!ok || wb_adr_o !== 30'h4 || wb_dat_o !== 32'hCAFE_F00D || wb_sel_o !== 4'b1100) begin
            failures++;
            $display("FAIL late_beat got adr=%h dat=%h sel=%b ok=%b exp adr=4 dat=cafef00d sel=1100",
                     wb_adr_o, wb_dat_o, wb_sel_o, ok);
        end
        ack_beat(32'h0, 1'b0);
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL late_end got cyc=%b rdy=%b exp cyc=0 rdy=1", wb_cyc_o, req_ready);
        end
    endtask

    task automatic test_err_read();
        bit ok;
        logic [31:0] exp_d [4];
        exp_d = '{32'h0000_00B0, 32'h0000_00B1, 32'hFFFF_FFFF, 32'h0000_00B3};
        drive_req(1'b0, 3'd4, 32'h0000_0300, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_stb(ok);
            checks++;
            if (!ok || wb_adr_o !== 30'hC0 + 30'(i)) begin
                failures++;
                $display("FAIL err_adr beat=%0d got=%h ok=%b exp=%h", i, wb_adr_o, ok,
                         30'hC0 + 30'(i));
            end
            if (i == 2) begin
                checks++;
                if (err_o !== 1'b0) begin
                    failures++;
                    $display("FAIL err_pre got=%b exp=0", err_o);
                end
            end
            ack_beat(32'hB0 + 32'(i), i == 2);
        end
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL err_flag got err=%b cyc=%b exp err=1 cyc=0", err_o, wb_cyc_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (read_valid !== 1'b1 || read_data !== exp_d[i]) begin
                failures++;
                $display("FAIL err_rdata idx=%0d got rv=%b rd=%h exp rv=1 rd=%h", i, read_valid,
                         read_data, exp_d[i]);
            end
            pop_rd();
        end
    endtask

    task automatic test_overflow();
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) push_wr(32'h7000_0000 + 32'(i));
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill got err=%b rdy=%b exp err=0 rdy=0", err_o, req_ready);
        end
        push_wr(32'h7000_0004);
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_err got=%b exp=1", err_o);
        end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive_req(1'b1, 3'd4, 32'h0000_0400, 4'hF, 1'b0);
        push_wr(32'h5555_AAAA);
        wait_stb(ok);
        checks++;
        if (!ok || wb_adr_o !== 30'h100) begin
            failures++;
            $display("FAIL mid_start got adr=%h ok=%b exp adr=100 ok=1", wb_adr_o, ok);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, err_o, read_valid} !== '0)
        begin
            failures++;
            $display("FAIL mid_reset got cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h err=%b rv=%b exp all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, err_o, read_valid);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checks++;
            if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_quiet cyc=%0d got stb=%b cyc=%b rdy=%b exp 0 0 1", i, wb_stb_o,
                         wb_cyc_o, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wrap_read();
        test_write_burst();
        test_write_late();
        test_err_read();
        test_overflow();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_wb_bridge.md
CPU_WB_BRIDGE -- requirements
Module: cpu_wb_bridge

Interface
REQ-001 Parameter: RD_DEPTH, 4, read buffer depth in 32-bit words (power of two, ≥4).
REQ-002 Parameter: WR_DEPTH, 4, write buffer depth in 32-bit words (power of two, ≥4).
REQ-003 Parameter: TMO_CYC, 255, cycles without ack before a beat is aborted (only used with the macro in REQ-022).
REQ-004 Ports, in order:
clk_i  in  1  single clock.
rst_ni  in  1  asynchronous, active-low reset.
req_valid  in  1  request strobe.
req_ready  out  1  request accepted when high together with req_valid.
req_len  in  3  beat count, 1 or 4.
req_mask  in  4  byte enables, bit 3 = byte at address offset 0.
req_addr  in  32  byte address.
req_we  in  1  1 = write.
req_wrap  in  1  wrap burst within 16-byte line.
write_valid  in  1  one-cycle write data strobe.
write_data  in  32  write data.
read_valid  out  1  read buffer non-empty.
read_data  out  32  read buffer head.
read_ack  in  1  pop read buffer.
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone classic master controls.
wb_adr_o  out  30  word address.
wb_sel_o  out  4  byte selects, same bit order as req_mask.
wb_dat_o  out  32  write data.
wb_dat_i  in  32  read data.
wb_ack_i, wb_err_i  in  1  cycle termination.
err_o  out  1  sticky error flag.

Function
REQ-005 req_ready SHALL equal (state==IDLE) AND read buffer empty AND write buffer empty, combinationally.
REQ-006 On req_valid&req_ready the block SHALL latch len, mask, addr, we and wrap, clear the beat counter and enter RD_BEAT (we=0) or WR_BEAT (we=1) next cycle.
REQ-007 States SHALL be IDLE, RD_BEAT, WR_BEAT and GAP; GAP lasts exactly one cycle between beats with wb_cyc_o held high and wb_stb_o low.
REQ-008 Beat n word address: len=4 with wrap=1 -> {addr[31:4], addr[3:2]+n (2-bit, wraps)}; len=4 with wrap=0 -> addr[31:2]+n; len=1 -> addr[31:2].
REQ-009 wb_sel_o SHALL equal the latched mask on every beat; wb_we_o SHALL equal the latched we.
REQ-010 wb_cyc_o SHALL rise with the first beat's wb_stb_o and fall in the cycle after the last beat terminates; wb_stb_o SHALL stay high until wb_ack_i or wb_err_i.
REQ-011 RD_BEAT: on wb_ack_i, wb_dat_i SHALL be pushed into the read buffer in the same edge.
REQ-012 WR_BEAT: wb_stb_o SHALL assert only while the write buffer is non-empty; wb_dat_o = write buffer head; pop on ack.
REQ-013 write_valid SHALL push write_data in any state; a push while full SHALL be dropped and set err_o.
REQ-014 read_valid = read buffer non-empty; read_data = head (first-word fall-through); read_ack with read_valid=0 SHALL be ignored.
REQ-015 Simultaneous push and pop on either buffer SHALL keep occupancy constant and preserve order.
REQ-016 wb_err_i SHALL terminate the beat as if acked, set err_o, and push 32'hFFFF_FFFF on reads; the burst continues.
REQ-017 After the beat with counter == len-1 terminates, state SHALL return to IDLE.
REQ-018 len values other than 4 SHALL be treated as 1.

Reset
REQ-019 rst_ni low SHALL immediately force: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0, err_o=0, both buffers empty (read_valid=0).
REQ-020 Reset mid-burst SHALL abandon the burst; no further Wishbone activity until a new request.
REQ-021 req_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-022 Macro CPU_WB_BRIDGE_TIMEOUT_EN: when defined, a per-beat counter SHALL abort any beat lacking ack/err after TMO_CYC cycles, behaving as wb_err_i (REQ-016); when undefined, beats wait indefinitely and the counter is absent.

Structure
REQ-023 Package cpu_bus_pkg SHALL hold the state enumeration, the req_len encodings (1, 4), the error fill word 32'hFFFF_FFFF and the default TMO_CYC.
REQ-024 Both buffers SHALL be instances of one sub-module bridge_fifo (parameterized width/depth, FWFT, full/empty flags).

Verification
REQ-025 Single read addr=0x0000_1006, mask=4'b0011, ack after 2 cycles with 0xDEAD_BEEF -> wb_adr_o=0x401, wb_sel_o=0011, read_data=0xDEAD_BEEF, req_ready returns after read_ack.
REQ-026 Wrapped read len=4 addr=0x0000_0108 -> wb_adr_o sequence 0x42,0x43,0x40,0x41, one GAP cycle between beats, cyc low after 4th ack.
REQ-027 Write len=4, data 0x11..,0x22..,0x33..,0x44.. strobed before any ack -> four beats in order, wb_dat_o matches, no err_o.
REQ-028 Write len=1 with write_valid 3 cycles after acceptance -> wb_stb_o low until data arrives, then one beat.
REQ-029 wb_err_i on beat 2 of a 4-beat read -> err_o=1, third buffered word 0xFFFF_FFFF, burst completes.
REQ-030 rst_ni pulsed low during beat 1 of a write burst -> all outputs reset within the same cycle, no further stb; with CPU_WB_BRIDGE_TIMEOUT_EN and no ack -> abort after 255 cycles.
